// File: rtl/rgb_to_gray.sv
// rgb_to_gray: RGB888 to 8-bit luma front end for the Sobel edge stage.
// Two-stage pipeline (products, then rounded sum) with valid/ready stall,
// plus column/row tracking that tags end-of-line and end-of-frame.
// Optional macro RGB2GRAY_BT709_EN selects BT.709 weights (default BT.601).
//
// Handshake: an input transfer happens when valid_in && ready_out; an output
// transfer happens when valid_out && ready_in. ready_out is combinational
// (no skid buffer): the whole pipeline moves only when the output register is
// empty or being drained, otherwise every stage register holds.
module rgb_to_gray #(
    parameter  int MAX_WIDTH  = 4096,
    parameter  int MAX_HEIGHT = 65536,
    localparam int WW         = $clog2(MAX_WIDTH),
    localparam int HW         = $clog2(MAX_HEIGHT)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          valid_in,
    output logic          ready_out,
    input  logic [23:0]   rgb_in,
    input  logic [WW-1:0] image_width,
    input  logic [HW-1:0] image_height,
    input  logic          ready_in,
    output logic          valid_out,
    output logic [7:0]    pixel_out,
    output logic          eol_out,
    output logic          eof_out
);

`ifdef RGB2GRAY_BT709_EN
    localparam logic [7:0] COEF_R = 8'd54;
    localparam logic [7:0] COEF_G = 8'd183;
    localparam logic [7:0] COEF_B = 8'd19;
`else
    localparam logic [7:0] COEF_R = 8'd77;
    localparam logic [7:0] COEF_G = 8'd150;
    localparam logic [7:0] COEF_B = 8'd29;
`endif

    logic          advance;
    logic          accept;
    logic          frame_start;
    logic          eol_now;
    logic          eof_now;
    logic [WW-1:0] width_eff;
    logic [HW-1:0] height_eff;

    logic [WW-1:0] col;
    logic [HW-1:0] row;
    logic [WW-1:0] w_lat;
    logic [HW-1:0] h_lat;

    logic [15:0]   mul_r;
    logic [15:0]   mul_g;
    logic [15:0]   mul_b;

    logic          v1;
    logic          eol1;
    logic          eof1;
    logic [15:0]   p_r;
    logic [15:0]   p_g;
    logic [15:0]   p_b;

    logic [16:0]   sum;
    logic [7:0]    luma;

    assign advance   = !valid_out || ready_in;
    assign ready_out = advance;
    assign accept    = valid_in && advance;

    // The first pixel of a frame uses the live dimension ports; later pixels
    // use the values latched at that first pixel.
    assign frame_start = (col == '0) && (row == '0);
    assign width_eff   = frame_start ? image_width  : w_lat;
    assign height_eff  = frame_start ? image_height : h_lat;
    assign eol_now     = (col == width_eff - WW'(1));
    assign eof_now     = eol_now && (row == height_eff - HW'(1));

    assign mul_r = 16'(rgb_in[23:16]) * 16'(COEF_R);
    assign mul_g = 16'(rgb_in[15:8])  * 16'(COEF_G);
    assign mul_b = 16'(rgb_in[7:0])   * 16'(COEF_B);

    // Weights sum to 256, so the rounded quotient never exceeds 255.
    assign sum  = {1'b0, p_r} + {1'b0, p_g} + {1'b0, p_b} + 17'd128;
    assign luma = 8'(sum >> 8);

    // Position counters and dimension latch, stepped by accepted pixels only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col   <= '0;
            row   <= '0;
            w_lat <= '0;
            h_lat <= '0;
        end else if (accept) begin
            if (frame_start) begin
                w_lat <= image_width;
                h_lat <= image_height;
            end
            if (eol_now) begin
                col <= '0;
                row <= eof_now ? '0 : row + HW'(1);
            end else begin
                col <= col + WW'(1);
            end
        end
    end

    // Stage 1: capture valid, position tags and the three weighted products.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1   <= 1'b0;
            eol1 <= 1'b0;
            eof1 <= 1'b0;
            p_r  <= '0;
            p_g  <= '0;
            p_b  <= '0;
        end else if (advance) begin
            v1   <= valid_in;
            eol1 <= accept && eol_now;
            eof1 <= accept && eof_now;
            p_r  <= mul_r;
            p_g  <= mul_g;
            p_b  <= mul_b;
        end
    end

    // Stage 2: rounded luma and tags into the output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out <= 1'b0;
            pixel_out <= '0;
            eol_out   <= 1'b0;
            eof_out   <= 1'b0;
        end else if (advance) begin
            valid_out <= v1;
            pixel_out <= luma;
            eol_out   <= v1 && eol1;
            eof_out   <= v1 && eof1;
        end
    end

endmodule

// File: tb/tb_rgb_to_gray.sv
// Bench for rgb_to_gray: a driver pushes expected {cycle, eof, eol, luma}
// entries into exp_q as pixels are accepted; a monitor pops and compares
// every output transfer.
`timescale 1ns/1ps
module tb_rgb_to_gray;
    localparam int WW = 12;
    localparam int HW = 16;

`ifdef RGB2GRAY_BT709_EN
    localparam int CR = 54;
    localparam int CG = 183;
    localparam int CB = 19;
`else
    localparam int CR = 77;
    localparam int CG = 150;
    localparam int CB = 29;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          valid_in = 1'b0;
    logic          ready_in = 1'b1;
    logic [23:0]   rgb_in = '0;
    logic [WW-1:0] image_width = WW'(4);
    logic [HW-1:0] image_height = HW'(2);
    logic          ready_out;
    logic          valid_out;
    logic [7:0]    pixel_out;
    logic          eol_out;
    logic          eof_out;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit chk_lat = 1'b0;

    logic [41:0] exp_q[$];
    int          bub_q[$];
    int          m_col = 0;
    int          m_row = 0;
    int          m_w = 0;
    int          m_h = 0;

    rgb_to_gray dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid_in     (valid_in),
        .ready_out    (ready_out),
        .rgb_in       (rgb_in),
        .image_width  (image_width),
        .image_height (image_height),
        .ready_in     (ready_in),
        .valid_out    (valid_out),
        .pixel_out    (pixel_out),
        .eol_out      (eol_out),
        .eof_out      (eof_out)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [7:0] luma_model(input logic [23:0] c);
        int s;
        s = CR * int'(c[23:16]) + CG * int'(c[15:8]) + CB * int'(c[7:0]) + 128;
        return 8'(s / 256);
    endfunction

    // Reference position model: pushes one expected entry per accepted pixel.
    task automatic model_push(input logic [23:0] c);
        logic eol;
        logic eof;
        if (m_col == 0 && m_row == 0) begin
            m_w = int'(image_width);
            m_h = int'(image_height);
        end
        eol = (m_col == m_w - 1);
        eof = eol && (m_row == m_h - 1);
        if (eol) begin
            m_col = 0;
            m_row = eof ? 0 : m_row + 1;
        end else begin
            m_col = m_col + 1;
        end
        exp_q.push_back({32'(cyc), eof, eol, luma_model(c)});
    endtask

    // Driver: called at a falling edge; returns at the falling edge after acceptance.
    task automatic send(input logic [23:0] c);
        bit done = 1'b0;
        valid_in = 1'b1;
        rgb_in = c;
        for (int i = 0; i < 50 && !done; i++) begin
            #1;
            if (ready_out === 1'b1) begin
                model_push(c);
                done = 1'b1;
            end
            @(negedge clk);
        end
        valid_in = 1'b0;
        if (!done) begin
            total++;
            bad++;
            $display("FAIL send_timeout: pixel %06h not accepted within 50 cycles", c);
        end
    endtask

    task automatic bubble();
        valid_in = 1'b0;
        bub_q.push_back(cyc);
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d pixels still pending, required 0", exp_q.size());
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        valid_in = 1'b0;
        exp_q.delete();
        bub_q.delete();
        m_col = 0;
        m_row = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: scoreboard compare of every output transfer, plus bubble gaps.
    always @(negedge clk) begin
        logic [41:0] e;
        #3;
        if (rst_n === 1'b1) begin
            if (chk_lat && bub_q.size() > 0 && bub_q[0] + 2 == cyc) begin
                void'(bub_q.pop_front());
                total++;
                if (valid_out !== 1'b0) begin
                    bad++;
                    $display("FAIL bubble_gap: valid_out=%b at cycle %0d, required 0", valid_out, cyc);
                end
            end
            if (valid_out === 1'b1 && ready_in === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_output: pixel=%0d eol=%b eof=%b with nothing pending", pixel_out, eol_out, eof_out);
                end else begin
                    e = exp_q.pop_front();
                    if ({eof_out, eol_out, pixel_out} !== e[9:0]) begin
                        bad++;
                        $display("FAIL output: got eof=%b eol=%b pixel=%0d, required eof=%b eol=%b pixel=%0d", eof_out, eol_out, pixel_out, e[9], e[8], e[7:0]);
                    end
                    if (chk_lat) begin
                        total++;
                        if (cyc - int'(e[41:10]) != 2) begin
                            bad++;
                            $display("FAIL latency: got %0d cycles, required 2", cyc - int'(e[41:10]));
                        end
                    end
                end
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        total += 5;
        if (valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b, required 0", valid_out); end
        if (pixel_out !== 8'd0) begin bad++; $display("FAIL reset_pixel: got %0d, required 0", pixel_out); end
        if (eol_out !== 1'b0) begin bad++; $display("FAIL reset_eol: got %b, required 0", eol_out); end
        if (eof_out !== 1'b0) begin bad++; $display("FAIL reset_eof: got %b, required 0", eof_out); end
        if (ready_out !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b, required 1", ready_out); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_colors();
        logic [23:0] tab [4];
        tab[0] = 24'hFFFFFF;
        tab[1] = 24'hFF0000;
        tab[2] = 24'h00FF00;
        tab[3] = 24'h0000FF;
        chk_lat = 1'b1;
        for (int i = 0; i < 4; i++) send(tab[i]);
        for (int i = 0; i < 6; i++) send(24'($urandom_range(0, 24'hFFFFFF)));
        drain();
        chk_lat = 1'b0;
    endtask

    task automatic test_frame_flags();
        do_reset();
        image_width = WW'(4);
        image_height = HW'(2);
        for (int i = 0; i < 9; i++) send(24'($urandom_range(0, 24'hFFFFFF)));
        drain();
    endtask

    task automatic test_stall();
        logic       v0;
        logic [7:0] p0;
        for (int i = 0; i < 3; i++) send(24'($urandom_range(0, 24'hFFFFFF)));
        ready_in = 1'b0;
        valid_in = 1'b1;
        rgb_in = 24'h123456;
        #1;
        v0 = valid_out;
        p0 = pixel_out;
        for (int i = 0; i < 3; i++) begin
            total += 3;
            if (ready_out !== 1'b0) begin bad++; $display("FAIL stall_ready: got %b, required 0", ready_out); end
            if (valid_out !== 1'b1) begin bad++; $display("FAIL stall_valid: got %b, required 1", valid_out); end
            if (pixel_out !== p0 || valid_out !== v0) begin bad++; $display("FAIL stall_hold: got pixel %0d, required %0d", pixel_out, p0); end
            @(negedge clk);
            #1;
        end
        @(negedge clk);
        ready_in = 1'b1;
        send(24'h123456);
        for (int i = 0; i < 3; i++) send(24'($urandom_range(0, 24'hFFFFFF)));
        drain();
    endtask

    task automatic test_bubbles();
        do_reset();
        image_width = WW'(4);
        image_height = HW'(2);
        chk_lat = 1'b1;
        for (int r = 0; r < 3; r++) begin
            send(24'($urandom_range(0, 24'hFFFFFF)));
            bubble();
            bubble();
            send(24'($urandom_range(0, 24'hFFFFFF)));
        end
        drain();
        chk_lat = 1'b0;
    endtask

    task automatic test_width_change();
        do_reset();
        image_width = WW'(4);
        image_height = HW'(2);
        for (int i = 0; i < 2; i++) send(24'($urandom_range(0, 24'hFFFFFF)));
        image_width = WW'(3);
        for (int i = 0; i < 6; i++) send(24'($urandom_range(0, 24'hFFFFFF)));
        for (int i = 0; i < 6; i++) send(24'($urandom_range(0, 24'hFFFFFF)));
        drain();
    endtask

    task automatic test_async_reset();
        do_reset();
        image_width = WW'(4);
        image_height = HW'(2);
        send(24'hFF0000);
        send(24'h00FF00);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total += 4;
        if (valid_out !== 1'b0) begin bad++; $display("FAIL async_valid: got %b, required 0", valid_out); end
        if (pixel_out !== 8'd0) begin bad++; $display("FAIL async_pixel: got %0d, required 0", pixel_out); end
        if (eol_out !== 1'b0 || eof_out !== 1'b0) begin bad++; $display("FAIL async_flags: got eol=%b eof=%b, required 0 0", eol_out, eof_out); end
        if (ready_out !== 1'b1) begin bad++; $display("FAIL async_ready: got %b, required 1", ready_out); end
        exp_q.delete();
        m_col = 0;
        m_row = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        image_width = WW'(3);
        image_height = HW'(1);
        for (int i = 0; i < 3; i++) send(24'($urandom_range(0, 24'hFFFFFF)));
        drain();
    endtask

    task automatic test_tiny_frame();
        do_reset();
        image_width = WW'(1);
        image_height = HW'(1);
        for (int i = 0; i < 3; i++) send(24'($urandom_range(0, 24'hFFFFFF)));
        drain();
    endtask

    initial begin
        #1;
        test_reset();
        test_colors();
        test_frame_flags();
        test_stall();
        test_bubbles();
        test_width_change();
        test_async_reset();
        test_tiny_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
